// File: rtl/cdc_handshake_sync.sv
// -----------------------------------------------------------------------------
// cdc_handshake_sync
//   Carries a DW-bit word from src_clk to dst_clk using a 4-phase req/ack
//   handshake. Only the single-bit req and ack signals are synchronized; the
//   word itself sits in a source-domain hold register that is guaranteed stable
//   while req is high, so the destination can load it directly.
//
//   Each synchronizer chain is SYNC flops deep: the first stage is an async_ff
//   (metastability-model flop), the remaining SYNC-1 stages are plain flops.
//
//   Optional feature (compile-time macro CDC_HS_OVERRUN_DET_EN):
//     src_ovf becomes a sticky overrun flag, an internal 8-bit saturating
//     counter ovf_cnt counts dropped words, and each drop is reported in
//     simulation. Without the macro src_ovf is tied low.
//
// Ports
//   CLR      in   asynchronous active-low reset for both domains
//   src_clk  in   source clock
//   dst_clk  in   destination clock
//   src_vld  in   source word valid (ignored while src_busy=1)
//   src_data in   source word [DW-1:0]
//   src_busy out  transfer in flight
//   src_ovf  out  sticky overrun flag (0 unless CDC_HS_OVERRUN_DET_EN)
//   dst_vld  out  single dst_clk-cycle pulse per delivered word
//   dst_data out  last delivered word, held until the next one [DW-1:0]
// -----------------------------------------------------------------------------

// First synchronizer stage. In the full environment this is the metastability
// model; here it behaves as a plain resettable flop. TS/TH describe the
// setup/hold window that the model would use.
module async_ff #(
    parameter real TS = 0.5,
    parameter real TH = 0.5
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    // Negative windows are meaningless; the block exists only to tie the
    // window parameters into elaboration.
    if (TS < 0.0 || TH < 0.0) begin : g_window_invalid
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) q <= 1'b0;
        else      q <= d;
    end
endmodule

module cdc_handshake_sync #(
    parameter int  DW   = 32,
    parameter int  SYNC = 2,
    parameter real TS   = 0.5,
    parameter real TH   = 0.5
) (
    input  logic          CLR,
    input  logic          src_clk,
    input  logic          dst_clk,
    input  logic          src_vld,
    input  logic [DW-1:0] src_data,
    output logic          src_busy,
    output logic          src_ovf,
    output logic          dst_vld,
    output logic [DW-1:0] dst_data
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} src_state_t;
    typedef enum logic       {D_IDLE, D_ACK}         dst_state_t;

    src_state_t    src_state_reg, src_state_next;
    logic          req_reg, req_next;
    logic [DW-1:0] hold_reg, hold_next;

    dst_state_t    dst_state_reg, dst_state_next;
    logic          ack_reg, ack_next;
    logic          dst_vld_reg, dst_vld_next;
    logic [DW-1:0] dst_data_reg, dst_data_next;

    logic req_sync;  // req as seen in the dst domain
    logic ack_sync;  // ack as seen in the src domain

    // ---------------- synchronizer chains ----------------
    for (genvar gi = 0; gi < SYNC; gi++) begin : g_req_sync
        logic q;
        if (gi == 0) begin : g_meta
            async_ff #(.TS(TS), .TH(TH)) u_meta (
                .clk (dst_clk),
                .clr (CLR),
                .d   (req_reg),
                .q   (q)
            );
        end else begin : g_flop
            always_ff @(posedge dst_clk or negedge CLR) begin
                if (!CLR) q <= 1'b0;
                else      q <= g_req_sync[gi-1].q;
            end
        end
    end
    assign req_sync = g_req_sync[SYNC-1].q;

    for (genvar gi = 0; gi < SYNC; gi++) begin : g_ack_sync
        logic q;
        if (gi == 0) begin : g_meta
            async_ff #(.TS(TS), .TH(TH)) u_meta (
                .clk (src_clk),
                .clr (CLR),
                .d   (ack_reg),
                .q   (q)
            );
        end else begin : g_flop
            always_ff @(posedge src_clk or negedge CLR) begin
                if (!CLR) q <= 1'b0;
                else      q <= g_ack_sync[gi-1].q;
            end
        end
    end
    assign ack_sync = g_ack_sync[SYNC-1].q;

    // ---------------- source domain ----------------
    always_ff @(posedge src_clk or negedge CLR) begin
        if (!CLR) begin
            src_state_reg <= S_IDLE;
            req_reg       <= 1'b0;
            hold_reg      <= '0;
        end else begin
            src_state_reg <= src_state_next;
            req_reg       <= req_next;
            hold_reg      <= hold_next;
        end
    end

    always_comb begin
        src_state_next = src_state_reg;
        req_next       = req_reg;
        hold_next      = hold_reg;
        case (src_state_reg)
            S_IDLE: begin
                if (src_vld) begin
                    src_state_next = S_REQ;
                    req_next       = 1'b1;
                    hold_next      = src_data;
                end
            end
            S_REQ: begin
                if (ack_sync) begin
                    src_state_next = S_DROP;
                    req_next       = 1'b0;
                end
            end
            S_DROP: begin
                // Wait for ack to fall so the next req edge is unambiguous.
                if (!ack_sync) src_state_next = S_IDLE;
            end
            default: begin
                src_state_next = S_IDLE;
                req_next       = 1'b0;
            end
        endcase
    end

    assign src_busy = (src_state_reg != S_IDLE);

`ifdef CDC_HS_OVERRUN_DET_EN
    logic       ovf_reg;
    logic [7:0] ovf_cnt;
    logic       drop;

    assign drop = src_vld & src_busy;

    always_ff @(posedge src_clk or negedge CLR) begin
        if (!CLR) begin
            ovf_reg <= 1'b0;
            ovf_cnt <= 8'h00;
        end else if (drop) begin
            ovf_reg <= 1'b1;
            if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge src_clk) begin
        if (CLR && drop) $display("cdc overrun at %m");
    end
`endif

    assign src_ovf = ovf_reg;
`else
    assign src_ovf = 1'b0;
`endif

    // ---------------- destination domain ----------------
    always_ff @(posedge dst_clk or negedge CLR) begin
        if (!CLR) begin
            dst_state_reg <= D_IDLE;
            ack_reg       <= 1'b0;
            dst_vld_reg   <= 1'b0;
            dst_data_reg  <= '0;
        end else begin
            dst_state_reg <= dst_state_next;
            ack_reg       <= ack_next;
            dst_vld_reg   <= dst_vld_next;
            dst_data_reg  <= dst_data_next;
        end
    end

    always_comb begin
        dst_state_next = dst_state_reg;
        ack_next       = ack_reg;
        dst_vld_next   = 1'b0;
        dst_data_next  = dst_data_reg;
        case (dst_state_reg)
            D_IDLE: begin
                // hold_reg has been stable since req rose, so it is safe to
                // load here even though it belongs to the src domain.
                if (req_sync) begin
                    dst_state_next = D_ACK;
                    dst_data_next  = hold_reg;
                    dst_vld_next   = 1'b1;
                    ack_next       = 1'b1;
                end
            end
            D_ACK: begin
                if (!req_sync) begin
                    dst_state_next = D_IDLE;
                    ack_next       = 1'b0;
                end
            end
            default: begin
                dst_state_next = D_IDLE;
                ack_next       = 1'b0;
            end
        endcase
    end

    assign dst_vld  = dst_vld_reg;
    assign dst_data = dst_data_reg;
endmodule
